// File: rtl/pb_event_pkg.sv
// Shared types for the push-button event decoder: channel state encoding,
// per-channel event bundle and a parameter range helper.
package pb_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB1,
    PRESS1,
    LONG,
    GAP,
    DEB2,
    WAIT_REL
  } pb_state_t;

  typedef struct packed {
    logic short;
    logic long_;
    logic double_;
    logic held;
  } pb_evt_t;

  // True when v is representable in an unsigned counter of w bits.
  function automatic bit pb_fits(int unsigned v, int unsigned w);
    return (w >= 32) || (v < (32'd1 << w));
  endfunction

endpackage

// File: rtl/pb_event_decoder_if.sv
// Button level inputs and per-channel event outputs of the decoder.
interface pb_event_decoder_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] pb;
  logic [N_CH-1:0] short_p;
  logic [N_CH-1:0] long_p;
  logic [N_CH-1:0] double_p;
  logic [N_CH-1:0] held;

  modport master (output pb, input short_p, long_p, double_p, held);
  modport slave  (input pb, output short_p, long_p, double_p, held);
endinterface

// File: rtl/pb_channel_fsm.sv
// One button channel: 2-flop synchroniser, gesture FSM and shared timer.
// Events are registered so each pulse lasts exactly one cycle.
module pb_channel_fsm
  import pb_event_pkg::*;
#(
  parameter int DEBOUNCE_P = 300,
  parameter int LONG_T     = 5000,
  parameter int DCLICK_EN  = 1,
  parameter int DCLICK_T   = 2000,
  parameter int REPEAT_T   = 0,
  parameter int CNT_W      = 16
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    pb,
  output pb_evt_t evt
);

  if (DEBOUNCE_P < 1 || LONG_T < 1 || DCLICK_T < 1 || REPEAT_T < 0) begin : g_bad_min
    $error("pb_channel_fsm: timing parameters out of range");
  end
  if (!pb_fits(DEBOUNCE_P, CNT_W) || !pb_fits(LONG_T, CNT_W) ||
      !pb_fits(DCLICK_T, CNT_W) || !pb_fits(REPEAT_T, CNT_W)) begin : g_bad_width
    $error("pb_channel_fsm: CNT_W too narrow for timing parameters");
  end

  localparam int REP_LAST_I = (REPEAT_T > 0) ? REPEAT_T - 1 : 0;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_P - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_T - 1);
  localparam logic [CNT_W-1:0] DCLK_LAST = CNT_W'(DCLICK_T - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_LAST_I);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             s_pb;
  pb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pb_evt_t          evt_d;

  assign s_pb = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    evt_d   = '0;
    case (state_q)
      IDLE: if (s_pb) state_d = DEB1;
      DEB1: begin
        if (!s_pb)                 state_d = IDLE;
        else if (cnt_q == DEB_LAST) state_d = PRESS1;
      end
      PRESS1: begin
        if (!s_pb) begin
          if (DCLICK_EN != 0) state_d = GAP;
          else begin
            state_d     = IDLE;
            evt_d.short = 1'b1;
          end
        end else if (cnt_q == LONG_LAST) begin
          state_d     = LONG;
          evt_d.long_ = 1'b1;
        end
      end
      LONG: begin
        if (!s_pb) state_d = IDLE;
        else if (REPEAT_T > 0 && cnt_q == REP_LAST) begin
          evt_d.long_ = 1'b1;
          cnt_d       = '0;
        end else if (cnt_q == '1) cnt_d = cnt_q;
      end
      // A press landing on the expiry cycle beats the pending short_p.
      GAP: begin
        if (s_pb) state_d = DEB2;
        else if (cnt_q == DCLK_LAST) begin
          state_d     = IDLE;
          evt_d.short = 1'b1;
        end
      end
      DEB2: begin
        if (!s_pb) begin
          state_d     = IDLE;
          evt_d.short = 1'b1;
        end else if (cnt_q == DEB_LAST) begin
          state_d       = WAIT_REL;
          evt_d.double_ = 1'b1;
        end
      end
      WAIT_REL: if (!s_pb) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    evt_d.held = (state_d == LONG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      evt     <= '0;
    end else begin
      sync_q  <= {sync_q[0], pb};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt     <= evt_d;
    end
  end

endmodule

// File: rtl/pb_event_decoder.sv
// Multi-channel push-button decoder: N_CH independent channel FSMs whose
// event bundles are unpacked onto the per-event output vectors.
module pb_event_decoder
  import pb_event_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DEBOUNCE_P = 300,
  parameter int LONG_T     = 5000,
  parameter int DCLICK_EN  = 1,
  parameter int DCLICK_T   = 2000,
  parameter int REPEAT_T   = 0,
  parameter int CNT_W      = 16
) (
  input logic clk,
  input logic rst,
  pb_event_decoder_if.slave bus
);

  pb_evt_t [N_CH-1:0] evt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pb_channel_fsm #(
      .DEBOUNCE_P (DEBOUNCE_P),
      .LONG_T     (LONG_T),
      .DCLICK_EN  (DCLICK_EN),
      .DCLICK_T   (DCLICK_T),
      .REPEAT_T   (REPEAT_T),
      .CNT_W      (CNT_W)
    ) u_fsm (
      .clk (clk),
      .rst (rst),
      .pb  (bus.pb[i]),
      .evt (evt[i])
    );
    assign bus.short_p[i]  = evt[i].short;
    assign bus.long_p[i]   = evt[i].long_;
    assign bus.double_p[i] = evt[i].double_;
    assign bus.held[i]     = evt[i].held;
  end

endmodule
